// File: rtl/led_seq_pkg.sv
// rtl/led_seq_pkg.sv - shared state encoding and colour constants for the LED phase sequencer
package led_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Active-low RGB: a 0 bit lights that colour.
  localparam logic [2:0] RED   = 3'b110;
  localparam logic [2:0] BLUE  = 3'b011;
  localparam logic [2:0] GREEN = 3'b101;
  localparam logic [2:0] OFF   = 3'b111;

  function automatic int width_of(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/led_phase_sequencer_debounce.sv
// rtl/led_phase_sequencer_debounce.sv - button synchroniser, counter debouncer and press pulse
module button_debounce
  import led_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 270000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic level,
  output logic press
);

  localparam int CW = width_of(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level_q;
  logic [CW-1:0] cnt;
  logic [1:0]    fill;
  logic          armed;

  // Presses are only honoured once a real synchronised sample has shown the
  // button released, so a button held through reset cannot fire on its own.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      level   <= 1'b1;
      level_q <= 1'b1;
      cnt     <= '0;
      press   <= 1'b0;
      fill    <= 2'b00;
      armed   <= 1'b0;
    end else begin
      sync1   <= btn_n;
      sync2   <= sync1;
      level_q <= level;
      fill    <= {fill[0], 1'b1};
      armed   <= armed | (fill[1] & sync2);
      press   <= armed & level_q & ~level;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_phase_sequencer.sv
// rtl/led_phase_sequencer.sv - steps an active-low RGB LED through programmable colour phases
module led_phase_sequencer
  import led_seq_pkg::*;
#(
  parameter int NUM_PHASES      = 3,
  parameter int LED_W           = 3,
  parameter int PHASE_CYCLES    = 30000000,
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter logic [NUM_PHASES*LED_W-1:0] PATTERNS = {GREEN, BLUE, RED}
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                button_start_n,
  input  logic                                button_stop_n,
  input  logic                                one_shot,
  output logic [LED_W-1:0]                    led,
  output logic [width_of(NUM_PHASES)-1:0]     phase,
  output logic                                running
);

  localparam int PW  = width_of(NUM_PHASES);
  localparam int CTW = width_of(PHASE_CYCLES);
  localparam logic [PW-1:0]  PH_LAST  = PW'(NUM_PHASES - 1);
  localparam logic [CTW-1:0] CNT_LAST = CTW'(PHASE_CYCLES - 1);

  if (NUM_PHASES < 1) begin : g_bad_num_phases
    $fatal(1, "NUM_PHASES must be at least 1");
  end
  if (PHASE_CYCLES < 1) begin : g_bad_phase_cycles
    $fatal(1, "PHASE_CYCLES must be at least 1");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce_cycles
    $fatal(1, "DEBOUNCE_CYCLES must be at least 1");
  end
  if ($bits(PATTERNS) != NUM_PHASES * LED_W) begin : g_bad_patterns
    $fatal(1, "PATTERNS width must be NUM_PHASES*LED_W");
  end

  function automatic logic [LED_W-1:0] pattern(input logic [PW-1:0] idx);
    return PATTERNS[int'(idx)*LED_W +: LED_W];
  endfunction

  logic start_level;
  logic start_press;
  logic stop_level;
  logic stop_press;
  logic unused_levels;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
    .clk   (clk),
    .rst   (rst),
    .btn_n (button_start_n),
    .level (start_level),
    .press (start_press)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_stop (
    .clk   (clk),
    .rst   (rst),
    .btn_n (button_stop_n),
    .level (stop_level),
    .press (stop_press)
  );

  assign unused_levels = start_level ^ stop_level;

  state_t           state;
  state_t           state_n;
  logic [CTW-1:0]   cnt;
  logic [CTW-1:0]   cnt_n;
  logic [PW-1:0]    phase_n;
  logic [LED_W-1:0] led_n;
  logic             running_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      phase   <= '0;
      led     <= '1;
      running <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      phase   <= phase_n;
      led     <= led_n;
      running <= running_n;
    end
  end

  // Outputs are computed alongside the next state so they change on the
  // same edge as the transition; stop always beats a coincident start.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    phase_n   = phase;
    led_n     = led;
    running_n = running;
    if (stop_press) begin
      state_n   = IDLE;
      cnt_n     = '0;
      phase_n   = '0;
      led_n     = '1;
      running_n = 1'b0;
    end else if (start_press) begin
      state_n   = RUN;
      cnt_n     = '0;
      phase_n   = '0;
      led_n     = pattern('0);
      running_n = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (cnt == CNT_LAST) begin
            cnt_n = '0;
            if (phase != PH_LAST) begin
              phase_n = phase + 1'b1;
              led_n   = pattern(phase_n);
            end else if (!one_shot) begin
              phase_n = '0;
              led_n   = pattern('0);
            end else begin
              state_n   = HOLD;
              running_n = 1'b0;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        HOLD: begin
          cnt_n = '0;
        end
        default: begin
          state_n   = IDLE;
          cnt_n     = '0;
          phase_n   = '0;
          led_n     = '1;
          running_n = 1'b0;
        end
      endcase
    end
  end

endmodule
